fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter ROM_WORDS, default 32, number of valid 32-bit instruction ROM words.
REQ-003 SHALL have parameter DEPTH, default 2, fetch buffer entries (power of 2, >=2).
REQ-004 SHALL have ports, one per line:
  clk             in   1   single clock, all state updates on rising edge
  rst_n           in   1   synchronous, active-low reset
  rom_addr        out  32  byte address driven to instruction ROM (ROM indexes by addr[31:2])
  rom_instr       in   32  ROM read data, combinational from rom_addr in the same cycle
  redirect_valid  in   1   branch/jump redirect request
  redirect_pc     in   32  redirect target byte address
  halt_req        in   1   level request to stop fetching
  out_valid       out  1   buffer head holds a valid instruction
  out_ready       in   1   decode accepts head
  out_pc          out  32  PC of head entry
  out_instr       out  32  instruction of head entry
  halted          out  1   state == HALTED
  fault           out  1   state == FAULT
  fault_pc        out  32  PC that caused the fault

Function
REQ-005 SHALL implement states RESET, RUN, HALTED, FAULT.
REQ-006 SHALL drive rom_addr = pc register combinationally in every state.
REQ-007 RESET SHALL move to RUN on the next edge, with no fetch.
REQ-008 In RUN, fetch condition = no redirect, no halt_req, pc legal, and (count < DEPTH or pop this cycle).
REQ-009 On fetch, SHALL push {pc, rom_instr} into the buffer and set pc <= pc + 4 (32-bit wrap).
REQ-010 A pc is legal when pc[1:0] == 0 and pc[31:2] < ROM_WORDS.
REQ-011 In RUN with an illegal pc, no redirect, and no halt_req: SHALL not push, set fault_pc <= pc, and go to FAULT.
REQ-012 Pop SHALL occur when out_valid && out_ready; head advances on that edge.
REQ-013 out_valid = (count != 0); out_pc/out_instr SHALL come from the head entry and be stable while out_valid && !out_ready.
REQ-014 Simultaneous push and pop when full SHALL be allowed; count is unchanged.
REQ-015 Head-to-output latency: an instruction fetched at edge N SHALL be visible on out_* after edge N (1 cycle from address to output).
REQ-016 redirect_valid SHALL take priority in every state except RESET: flush buffer (count <= 0), pc <= redirect_pc, no push, and no pop that cycle.
REQ-017 After redirect the state SHALL be RUN (also from HALTED and FAULT), and fault_pc SHALL be held.
REQ-018 redirect_valid and halt_req together: redirect wins, halt_req is ignored that cycle.
REQ-019 halt_req in RUN, no redirect: no push, buffer keeps draining via pops, state <= HALTED.
REQ-020 In HALTED, SHALL stay until redirect_valid; halt_req deassertion alone does not resume.
REQ-021 FAULT SHALL be left only by redirect or reset; the buffer keeps draining in FAULT.
REQ-022 pc wrap 32'hFFFF_FFFC -> 0 SHALL be plain modulo arithmetic, with legality checked on the next fetch.

Reset
REQ-023 On a rising edge with rst_n == 0: state <= RESET, pc <= RESET_PC, count <= 0, buffer pointers <= 0, fault_pc <= 0.
REQ-024 Reset SHALL override all inputs, including mid-operation redirect/halt; outputs after that edge: out_valid=0, halted=0, fault=0, rom_addr=RESET_PC.
REQ-025 First out_valid SHALL rise after the 2nd rising edge with rst_n == 1 (RESET->RUN, then first fetch).

Verification
REQ-026 ROM[0..3] = 11,22,33,44, out_ready=1 constantly -> out_pc 0,4,8,12 on consecutive cycles with matching instrs, one per cycle.
REQ-027 out_ready=0 for 5 cycles after reset -> count saturates at 2 (pcs 0,4), rom_addr holds 8, no loss; out_ready=1 -> pcs 0,4,8 in order.
REQ-028 Redirect to 0x40 with 2 entries buffered -> out_valid=0 next cycle, then out_pc=0x40; ROM_WORDS=32 so 0x40 is legal.
REQ-029 Redirect to 0x7C, run -> 0x7C delivered, then fault=1, fault_pc=0x80, no entry at 0x80; redirect 0x0 -> fault=0, resumes at 0.
REQ-030 halt_req with redirect in the same cycle -> RUN at target; halt_req alone -> halted=1, buffer drains, rom_addr frozen; rst_n=0 mid-halt -> all REQ-024 values.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks the PC through a combinational ROM into a small
// in-order fetch buffer, with redirect, halt and illegal-PC fault handling.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 32,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_pc
);
    localparam int                AW        = $clog2(DEPTH);
    localparam logic [AW:0]       FULL      = (AW+1)'(DEPTH);
    localparam logic [31:0]       ROM_LIMIT = ROM_WORDS;

    typedef enum logic [1:0] {S_RESET, S_RUN, S_HALTED, S_FAULT} state_t;

    state_t          r_state, w_state_nxt;
    logic [31:0]     r_pc, w_pc_nxt;
    logic [31:0]     r_fault_pc, w_fault_pc_nxt;
    logic [AW:0]     r_count;
    logic [AW-1:0]   r_head, r_tail;
    logic [31:0]     r_buf_pc    [DEPTH];
    logic [31:0]     r_buf_instr [DEPTH];
    logic            w_legal, w_pop, w_push, w_flush;

    assign w_legal = (r_pc[1:0] == 2'b00) && ({2'b00, r_pc[31:2]} < ROM_LIMIT);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_fault_pc_nxt = r_fault_pc;
        w_push         = 1'b0;
        w_flush        = 1'b0;
        w_pop          = out_valid && out_ready;
        case (r_state)
            S_RESET: w_state_nxt = S_RUN;
            default: begin
                // Redirect beats everything, including a pending pop of stale entries.
                if (redirect_valid) begin
                    w_flush     = 1'b1;
                    w_pop       = 1'b0;
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = S_RUN;
                end else if (r_state == S_RUN) begin
                    if (halt_req) begin
                        w_state_nxt = S_HALTED;
                    end else if (!w_legal) begin
                        w_fault_pc_nxt = r_pc;
                        w_state_nxt    = S_FAULT;
                    end else if (r_count < FULL || w_pop) begin
                        w_push   = 1'b1;
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_RESET;
            r_pc       <= RESET_PC;
            r_fault_pc <= 32'h0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_fault_pc <= w_fault_pc_nxt;
            if (w_flush) begin
                r_count <= '0;
                r_head  <= '0;
                r_tail  <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + 1'b1;
                if (w_pop)  r_head <= r_head + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload storage needs no reset; out_valid gates its visibility.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_buf_pc[r_tail]    <= r_pc;
            r_buf_instr[r_tail] <= rom_instr;
        end
    end

    assign rom_addr  = r_pc;
    assign out_valid = (r_count != '0);
    assign out_pc    = r_buf_pc[r_head];
    assign out_instr = r_buf_instr[r_head];
    assign halted    = (r_state == S_HALTED);
    assign fault     = (r_state == S_FAULT);
    assign fault_pc  = r_fault_pc;

endmodule
